pool_channel_sequencer: RTL and testbench

Controller that runs the 2x2 max-pooling stage over NUM_CH feature maps held in an on-chip buffer. For each channel it streams pixels in raster order from the source buffer into the pooling datapath and writes pooled results to the destination buffer. Between channels it pulses the pooling unit's ack to clear its row counter, then reports completion of the whole layer. It sits between the conv-layer output RAM and the next layer's input RAM.

---
 rtl/pool_channel_sequencer_pkg.sv | 35 +++
 rtl/pool_channel_sequencer_addr_gen.sv | 56 +++++
 rtl/pool_channel_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_pool_channel_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_channel_sequencer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pool_channel_sequencer_pkg
// Description : Shared definitions for the pooling channel sequencer:
//               controller state encoding and a ceil(log2) helper used
//               to size address and channel-index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package pool_channel_sequencer_pkg;

    // Controller states, in the order a layer passes through them
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        ACK   = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Bits needed to index 0..value-1; never less than one bit
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pool_channel_sequencer_addr_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pool_channel_sequencer_addr_gen
// Description : Per-channel address generator. A base register advances by
//               STEP at each channel boundary (no multiplier); an offset
//               counter walks 0..STEP-1 and wraps. addr = base + offset.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_channel_sequencer_addr_gen
    import pool_channel_sequencer_pkg::*;
#(
    parameter int AW   = 8,
    parameter int STEP = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          off_clr,
    input  logic          inc,
    input  logic          adv,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] c_step = AW'(STEP);
    localparam logic [AW-1:0] c_last = AW'(STEP - 1);

    logic [AW-1:0] r_base;
    logic [AW-1:0] r_off;

    // Base accumulates one channel stride per boundary; offset wraps at the stride
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_base <= '0;
            r_off  <= '0;
        end else if (clear) begin
            r_base <= '0;
            r_off  <= '0;
        end else begin
            if (adv) begin
                r_base <= r_base + c_step;
            end
            if (off_clr) begin
                r_off <= '0;
            end else if (inc) begin
                r_off <= last ? '0 : r_off + 1'b1;
            end
        end
    end

    assign last = (r_off == c_last);
    assign addr = r_base + r_off;

endmodule
`default_nettype wire

// File: rtl/pool_channel_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : pool_channel_sequencer
// Description : Runs 2x2 max-pooling over NUM_CH feature maps: streams each
//               map in raster order into the pooling unit, writes pooled
//               results out, acks the pooling unit between channels and
//               pulses all_done at the end of the layer.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_channel_sequencer
    import pool_channel_sequencer_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int WIDTH      = 28,
    parameter  int HEIGHT     = 28,
    parameter  int NUM_CH     = 8,
    localparam int ODD        = WIDTH % 2,
    localparam int IN_SZ      = WIDTH * HEIGHT,
    localparam int OUT_SZ     = ((HEIGHT - ODD) >> 1) * ((WIDTH - ODD) >> 1),
    localparam int RA_W       = clogb2(NUM_CH * IN_SZ),
    localparam int WA_W       = clogb2(NUM_CH * OUT_SZ),
    localparam int CH_W       = clogb2(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  all_done,
    output logic [CH_W-1:0]       ch_idx,
    output logic                  rd_en,
    output logic [RA_W-1:0]       rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  pool_valid_in,
    output logic [DATA_WIDTH-1:0] pool_data_in,
    output logic                  pool_ack,
    input  logic [DATA_WIDTH-1:0] pool_data_out,
    input  logic                  pool_valid_out,
    input  logic                  pool_done,
    output logic                  wr_en,
    output logic [WA_W-1:0]       wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CH_W-1:0] r_ch_idx;
    logic            r_pool_valid_in;
    logic            r_done_seen;
    logic            r_err;

    logic w_busy;
    logic w_rd_en;
    logic w_ack;
    logic w_all_done;
    logic w_run_clr;
    logic w_rd_last;
    logic w_wr_last;
    logic w_wr_fire;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-state strobes
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_rd_en     = 1'b0;
        w_ack       = 1'b0;
        w_all_done  = 1'b0;
        w_run_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_run_clr   = 1'b1;
                    w_state_nxt = FEED;
                end
            end
            FEED: begin
                w_busy  = 1'b1;
                w_rd_en = 1'b1;
                if (w_rd_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_busy = 1'b1;
                // The done pulse itself is accepted so the ack is not delayed a cycle
                if (r_done_seen || pool_done) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                w_busy      = 1'b1;
                w_ack       = 1'b1;
                w_state_nxt = (r_ch_idx == CH_W'(NUM_CH - 1)) ? FIN : FEED;
            end
            FIN: begin
                w_all_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Channel index, read-valid delay line, done latch and count-mismatch flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ch_idx        <= '0;
            r_pool_valid_in <= 1'b0;
            r_done_seen     <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_pool_valid_in <= w_rd_en;
            if (w_run_clr) begin
                r_ch_idx <= '0;
            end else if (w_ack && (w_state_nxt == FEED)) begin
                r_ch_idx <= r_ch_idx + 1'b1;
            end
            if (w_ack) begin
                r_done_seen <= 1'b0;
            end else if (w_busy && pool_done) begin
                r_done_seen <= 1'b1;
            end
            if (w_busy && pool_done && !w_wr_last) begin
                r_err <= 1'b1;
            end
        end
    end

    // Writes are only forwarded while a layer is running, so a reset aborts them
    assign w_wr_fire = pool_valid_out && w_busy;

    pool_channel_sequencer_addr_gen #(
        .AW   (RA_W),
        .STEP (IN_SZ)
    ) u_rd_addr (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (w_run_clr),
        .off_clr (w_ack),
        .inc     (w_rd_en),
        .adv     (w_ack),
        .addr    (rd_addr),
        .last    (w_rd_last)
    );

    pool_channel_sequencer_addr_gen #(
        .AW   (WA_W),
        .STEP (OUT_SZ)
    ) u_wr_addr (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (w_run_clr),
        .off_clr (w_ack),
        .inc     (w_wr_fire),
        .adv     (w_ack),
        .addr    (wr_addr),
        .last    (w_wr_last)
    );

    assign busy          = w_busy;
    assign all_done      = w_all_done;
    assign ch_idx        = r_ch_idx;
    assign rd_en         = w_rd_en;
    assign pool_valid_in = r_pool_valid_in;
    assign pool_data_in  = r_pool_valid_in ? rd_data : '0;
    assign pool_ack      = w_ack;
    assign wr_en         = w_wr_fire;
    assign wr_data       = w_wr_fire ? pool_data_out : '0;

endmodule
`default_nettype wire

// File: tb/tb_pool_channel_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pool_channel_sequencer
// Description : Scoreboard bench for the pooling channel sequencer. Two
//               instances (4x4 x2 channels, 5x5 x1 channel) are each paired
//               with a behavioural max-pool unit and an address-echo source
//               RAM; expected reads/writes are computed from the pooling
//               rules and popped by monitors on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pool_channel_sequencer;

    localparam int A_W = 4, A_H = 4, A_N = 2;
    localparam int B_W = 5, B_H = 5, B_N = 1;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- instance A: 4x4, 2 channels ----------------
    logic        a_start, a_busy, a_all_done, a_rd_en, a_pvi, a_ack, a_pvo, a_pdone, a_wr_en;
    logic [0:0]  a_ch_idx;
    logic [4:0]  a_rd_addr;
    logic [2:0]  a_wr_addr;
    logic [31:0] a_rd_data, a_pdi, a_pdo, a_wr_data;
    logic        a_mock, a_mock_done;

    pool_channel_sequencer #(.DATA_WIDTH(32), .WIDTH(A_W), .HEIGHT(A_H), .NUM_CH(A_N)) u_a (
        .clk(clk), .resetn(resetn), .start(a_start), .busy(a_busy), .all_done(a_all_done),
        .ch_idx(a_ch_idx), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .pool_valid_in(a_pvi), .pool_data_in(a_pdi), .pool_ack(a_ack),
        .pool_data_out(a_pdo), .pool_valid_out(a_pvo), .pool_done(a_pdone),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data)
    );

    // ---------------- instance B: 5x5, 1 channel ----------------
    logic        b_start, b_busy, b_all_done, b_rd_en, b_pvi, b_ack, b_pvo, b_pdone, b_wr_en;
    logic [0:0]  b_ch_idx;
    logic [4:0]  b_rd_addr;
    logic [1:0]  b_wr_addr;
    logic [31:0] b_rd_data, b_pdi, b_pdo, b_wr_data;

    pool_channel_sequencer #(.DATA_WIDTH(32), .WIDTH(B_W), .HEIGHT(B_H), .NUM_CH(B_N)) u_b (
        .clk(clk), .resetn(resetn), .start(b_start), .busy(b_busy), .all_done(b_all_done),
        .ch_idx(b_ch_idx), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .pool_valid_in(b_pvi), .pool_data_in(b_pdi), .pool_ack(b_ack),
        .pool_data_out(b_pdo), .pool_valid_out(b_pvo), .pool_done(b_pdone),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data)
    );

    // Source RAM whose content equals its address, one-cycle read latency
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= 32'(a_rd_addr);
        if (b_rd_en) b_rd_data <= 32'(b_rd_addr);
    end

    // Behavioural 2x2 max-pool unit for A: buffers the frame, emits a window max
    // one cycle after its bottom-right pixel, done with the final window
    logic [31:0] a_img [A_W*A_H];
    int          a_cnt;
    logic        a_mv, a_md;
    logic [31:0] a_mo;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_cnt <= 0; a_mv <= 1'b0; a_md <= 1'b0; a_mo <= '0;
        end else begin : a_pool
            int r, c, npr, npc;
            logic [31:0] mx;
            npr = (A_H - A_W % 2) / 2;
            npc = (A_W - A_W % 2) / 2;
            a_mv <= 1'b0;
            a_md <= 1'b0;
            if (a_ack) begin
                a_cnt <= 0;
            end else if (a_pvi && a_cnt < A_W * A_H) begin
                r = a_cnt / A_W;
                c = a_cnt % A_W;
                a_img[a_cnt] = a_pdi;
                a_cnt <= a_cnt + 1;
                if (r % 2 == 1 && c % 2 == 1 && r / 2 < npr && c / 2 < npc) begin
                    mx = a_img[a_cnt];
                    if (a_img[a_cnt-1] > mx) mx = a_img[a_cnt-1];
                    if (a_img[a_cnt-A_W] > mx) mx = a_img[a_cnt-A_W];
                    if (a_img[a_cnt-A_W-1] > mx) mx = a_img[a_cnt-A_W-1];
                    a_mv <= 1'b1;
                    a_mo <= mx;
                    a_md <= (r / 2 == npr - 1) && (c / 2 == npc - 1);
                end
            end
        end
    end
    assign a_pvo   = a_mock ? 1'b0 : a_mv;
    assign a_pdone = a_mock ? a_mock_done : a_md;
    assign a_pdo   = a_mo;

    // Behavioural 2x2 max-pool unit for B (odd size: last row/column dropped)
    logic [31:0] b_img [B_W*B_H];
    int          b_cnt;
    logic        b_mv, b_md;
    logic [31:0] b_mo;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            b_cnt <= 0; b_mv <= 1'b0; b_md <= 1'b0; b_mo <= '0;
        end else begin : b_pool
            int r, c, npr, npc;
            logic [31:0] mx;
            npr = (B_H - B_W % 2) / 2;
            npc = (B_W - B_W % 2) / 2;
            b_mv <= 1'b0;
            b_md <= 1'b0;
            if (b_ack) begin
                b_cnt <= 0;
            end else if (b_pvi && b_cnt < B_W * B_H) begin
                r = b_cnt / B_W;
                c = b_cnt % B_W;
                b_img[b_cnt] = b_pdi;
                b_cnt <= b_cnt + 1;
                if (r % 2 == 1 && c % 2 == 1 && r / 2 < npr && c / 2 < npc) begin
                    mx = b_img[b_cnt];
                    if (b_img[b_cnt-1] > mx) mx = b_img[b_cnt-1];
                    if (b_img[b_cnt-B_W] > mx) mx = b_img[b_cnt-B_W];
                    if (b_img[b_cnt-B_W-1] > mx) mx = b_img[b_cnt-B_W-1];
                    b_mv <= 1'b1;
                    b_mo <= mx;
                    b_md <= (r / 2 == npr - 1) && (c / 2 == npc - 1);
                end
            end
        end
    end
    assign b_pvo   = b_mv;
    assign b_pdone = b_md;
    assign b_pdo   = b_mo;

    // ---------------- scoreboard ----------------
    int  a_rq[$];
    int  b_rq[$];
    wr_t a_wq[$];
    wr_t b_wq[$];
    wr_t a_e, b_e;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected traffic for a full layer, from the pooling definition
    task automatic push_exp(input bit is_b, input bit with_wr);
        int w, h, n, in_sz, npr, npc, v, mx, odd;
        wr_t e;
        w = is_b ? B_W : A_W;
        h = is_b ? B_H : A_H;
        n = is_b ? B_N : A_N;
        odd = w % 2;
        in_sz = w * h;
        npr = (h - odd) / 2;
        npc = (w - odd) / 2;
        for (int ch = 0; ch < n; ch++)
            for (int i = 0; i < in_sz; i++)
                if (is_b) b_rq.push_back(ch * in_sz + i);
                else      a_rq.push_back(ch * in_sz + i);
        if (with_wr)
            for (int ch = 0; ch < n; ch++)
                for (int oy = 0; oy < npr; oy++)
                    for (int ox = 0; ox < npc; ox++) begin
                        mx = 0;
                        for (int dy = 0; dy < 2; dy++)
                            for (int dx = 0; dx < 2; dx++) begin
                                v = ch * in_sz + (2 * oy + dy) * w + 2 * ox + dx;
                                if (v > mx) mx = v;
                            end
                        e.addr = ch * npr * npc + oy * npc + ox;
                        e.data = mx;
                        if (is_b) b_wq.push_back(e);
                        else      a_wq.push_back(e);
                    end
    endtask

    // Monitors: pop and compare every read and write strobe
    always @(negedge clk) begin
        if (resetn) begin
            if (a_rd_en) begin
                if (a_rq.size() == 0) check("a_rd_pending", a_rq.size(), 1);
                else check("a_rd_addr", a_rd_addr, a_rq.pop_front());
            end
            if (a_wr_en) begin
                if (a_wq.size() == 0) check("a_wr_pending", a_wq.size(), 1);
                else begin
                    a_e = a_wq.pop_front();
                    check("a_wr_addr", a_wr_addr, a_e.addr);
                    check("a_wr_data", a_wr_data, a_e.data);
                end
            end
            if (b_rd_en) begin
                if (b_rq.size() == 0) check("b_rd_pending", b_rq.size(), 1);
                else check("b_rd_addr", b_rd_addr, b_rq.pop_front());
            end
            if (b_wr_en) begin
                if (b_wq.size() == 0) check("b_wr_pending", b_wq.size(), 1);
                else begin
                    b_e = b_wq.pop_front();
                    check("b_wr_addr", b_wr_addr, b_e.addr);
                    check("b_wr_data", b_wr_data, b_e.data);
                end
            end
        end
    end

    // Free-running event counters; tests compare deltas
    int a_n_pvi = 0, a_n_wr = 0, a_n_done = 0, a_n_ack = 0;
    int b_n_pvi = 0, b_n_wr = 0, b_n_done = 0, b_n_ack = 0;
    always @(negedge clk) begin
        if (a_pvi) a_n_pvi++;
        if (a_wr_en) a_n_wr++;
        if (a_all_done) a_n_done++;
        if (a_ack) a_n_ack++;
        if (b_pvi) b_n_pvi++;
        if (b_wr_en) b_n_wr++;
        if (b_all_done) b_n_done++;
        if (b_ack) b_n_ack++;
    end

    int sa_pvi, sa_wr, sa_done, sa_ack;
    task automatic snap_a();
        sa_pvi = a_n_pvi; sa_wr = a_n_wr; sa_done = a_n_done; sa_ack = a_n_ack;
    endtask
    task automatic counts_a(input string tag, input int pvi, input int wr, input int dn, input int ak);
        check({tag, "_pvi"},  a_n_pvi - sa_pvi, pvi);
        check({tag, "_wr"},   a_n_wr - sa_wr, wr);
        check({tag, "_done"}, a_n_done - sa_done, dn);
        check({tag, "_ack"},  a_n_ack - sa_ack, ak);
        check({tag, "_rq"},   a_rq.size(), 0);
        check({tag, "_wq"},   a_wq.size(), 0);
    endtask

    task automatic idle_a(input string tag);
        check({tag, "_busy"}, a_busy, 0);
        check({tag, "_all_done"}, a_all_done, 0);
        check({tag, "_rd_en"}, a_rd_en, 0);
        check({tag, "_rd_addr"}, a_rd_addr, 0);
        check({tag, "_pvi"}, a_pvi, 0);
        check({tag, "_pdi"}, a_pdi, 0);
        check({tag, "_ack"}, a_ack, 0);
        check({tag, "_wr_en"}, a_wr_en, 0);
        check({tag, "_wr_addr"}, a_wr_addr, 0);
        check({tag, "_wr_data"}, a_wr_data, 0);
        check({tag, "_ch_idx"}, a_ch_idx, 0);
    endtask

    task automatic pulse_a();
        @(negedge clk) a_start = 1'b1;
        @(negedge clk) a_start = 1'b0;
    endtask

    task automatic wait_a_done(input string tag, input int bound);
        int n;
        n = 0;
        while (!a_all_done && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_all_done_seen"}, a_all_done, 1);
        check({tag, "_busy_at_done"}, a_busy, 0);
    endtask

    initial begin : stim
        int n, m, sb_pvi, sb_wr, sb_done, sb_ack;
        resetn = 1'b0;
        a_start = 1'b0; b_start = 1'b0;
        a_mock = 1'b0; a_mock_done = 1'b0;
        a_rd_data = '0; b_rd_data = '0;

        // Reset state
        #17;
        idle_a("rst_a");
        check("rst_b_busy", b_busy, 0);
        check("rst_b_rd_en", b_rd_en, 0);
        check("rst_a_err", u_a.r_err, 0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);

        // Normal 4x4 x2 run
        snap_a();
        push_exp(1'b0, 1'b1);
        pulse_a();
        check("t1_busy_after_start", a_busy, 1);
        check("t1_first_rd", a_rd_en, 1);
        wait_a_done("t1", 300);
        repeat (4) @(negedge clk);
        counts_a("t1", 32, 8, 1, 2);
        check("t1_err", u_a.r_err, 0);

        // Odd 5x5 single channel; start during FIN is ignored
        sb_pvi = b_n_pvi; sb_wr = b_n_wr; sb_done = b_n_done; sb_ack = b_n_ack;
        push_exp(1'b1, 1'b1);
        @(negedge clk) b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        n = 0;
        while (!b_all_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t2_all_done_seen", b_all_done, 1);
        check("t2_ack_before_done", b_n_ack - sb_ack, 1);
        b_start = 1'b1;
        @(negedge clk) b_start = 1'b0;
        check("t2_fin_start_ignored", b_busy, 0);
        check("t2_fin_start_no_rd", b_rd_en, 0);
        repeat (4) @(negedge clk);
        check("t2_pvi", b_n_pvi - sb_pvi, 25);
        check("t2_wr", b_n_wr - sb_wr, 4);
        check("t2_done", b_n_done - sb_done, 1);
        check("t2_ack", b_n_ack - sb_ack, 1);
        check("t2_wq", b_wq.size(), 0);
        check("t2_err", u_b.r_err, 0);

        // Second start during FEED of ch0 is ignored
        snap_a();
        push_exp(1'b0, 1'b1);
        pulse_a();
        repeat (3) @(negedge clk);
        pulse_a();
        check("t3_ch_still0", a_ch_idx, 0);
        wait_a_done("t3", 300);
        repeat (4) @(negedge clk);
        counts_a("t3", 32, 8, 1, 2);

        // Asynchronous reset mid-FEED of ch1, then a clean run
        push_exp(1'b0, 1'b1);
        pulse_a();
        n = 0;
        while (!(a_ch_idx == 1'b1 && a_rd_en) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t4_reached_ch1", a_ch_idx, 1);
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1 idle_a("t4_rst");
        a_rq.delete();
        a_wq.delete();
        @(posedge clk) #2 resetn = 1'b1;
        @(negedge clk);
        snap_a();
        push_exp(1'b0, 1'b1);
        pulse_a();
        wait_a_done("t4", 300);
        repeat (4) @(negedge clk);
        counts_a("t4", 32, 8, 1, 2);

        // Back-to-back: start the cycle after all_done
        snap_a();
        push_exp(1'b0, 1'b1);
        pulse_a();
        wait_a_done("t5a", 300);
        push_exp(1'b0, 1'b1);
        pulse_a();
        check("t5_restart_busy", a_busy, 1);
        check("t5_restart_ch", a_ch_idx, 0);
        wait_a_done("t5b", 300);
        repeat (4) @(negedge clk);
        counts_a("t5", 64, 16, 2, 4);

        // Mocked pool_done injected during FEED
        a_mock = 1'b1;
        snap_a();
        push_exp(1'b0, 1'b0);
        pulse_a();
        for (int c = 0; c < A_N; c++) begin
            n = 0;
            while (!a_rd_en && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t6_feed", a_rd_en, 1);
            repeat (3) @(negedge clk);
            a_mock_done = 1'b1;
            @(negedge clk) a_mock_done = 1'b0;
            check("t6_done_seen", u_a.r_done_seen, 1);
            n = 0;
            while (a_rd_en && n < 50) begin
                @(negedge clk);
                n++;
            end
            m = 0;
            while (!a_ack && m < 50) begin
                @(negedge clk);
                m++;
            end
            check("t6_ack_gap", m, 1);
        end
        @(negedge clk);
        check("t6_all_done", a_all_done, 1);
        repeat (4) @(negedge clk);
        counts_a("t6", 32, 0, 1, 2);
        check("t6_err", u_a.r_err, 1);
        a_mock = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
